// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Define ARB_STATS_EN to add per-side grant counters.
module sram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
`ifdef ARB_STATS_EN
    ,
    parameter int unsigned STAT_W       = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_inst_grants,
    output logic [STAT_W-1:0] stat_data_grants
`endif
);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    logic             inst_pri;
    logic             grant_inst;
    logic             grant_data;
    logic [CNT_W-1:0] starve_cnt;
    logic             resp_valid;
    owner_t           resp_owner;

    // Grants are masked during reset so the combinational handshakes stay low.
    always_comb begin
        inst_pri   = (32'(starve_cnt) >= STARVE_LIMIT);
        grant_data = ~reset & data_req & ~(inst_req & inst_pri);
        grant_inst = ~reset & inst_req & ~grant_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
            resp_valid <= 1'b0;
            resp_owner <= OWN_INST;
        end else begin
            resp_valid <= grant_inst | grant_data;
            resp_owner <= grant_data ? OWN_DATA : OWN_INST;
            if (grant_inst || !inst_req) begin
                starve_cnt <= '0;
            end else if (grant_data && (starve_cnt != '1)) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_inst | grant_data;
        sram_we      = (grant_data && data_wr) ? data_wstrb : '0;
        sram_addr    = grant_data ? data_addr : (grant_inst ? inst_addr : '0);
        sram_wdata   = grant_data ? data_wdata : '0;
    end

    // A response still in flight when reset rises is suppressed, not delivered.
    always_comb begin
        inst_data_ok = ~reset & resp_valid & (resp_owner == OWN_INST);
        data_data_ok = ~reset & resp_valid & (resp_owner == OWN_DATA);
        inst_rdata   = inst_data_ok ? sram_rdata : '0;
        data_rdata   = data_data_ok ? sram_rdata : '0;
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_inst_grants <= '0;
            stat_data_grants <= '0;
        end else begin
            if (grant_inst) stat_inst_grants <= stat_inst_grants + 1'b1;
            if (grant_data) stat_data_grants <= stat_data_grants + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter with a behavioural SRAM model.
// Stats checks compile in only when ARB_STATS_EN is defined.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;
`ifdef ARB_STATS_EN
    logic [31:0] stat_inst_grants, stat_data_grants;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int          cyc;
        logic        chk;
        logic [31:0] val;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    logic [31:0] mem [logic [31:0]];

    sram_port_arbiter #(
        .STARVE_LIMIT(4),
        .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
`ifdef ARB_STATS_EN
        ,
        .stat_inst_grants(stat_inst_grants), .stat_data_grants(stat_data_grants)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first SRAM: data appears the cycle after sram_en.
    always @(posedge clk) begin
        logic [31:0] w;
        if (sram_en) begin
            w = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
            sram_rdata <= w;
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
            if (sram_we != 4'h0) mem[sram_addr] = w;
        end
    end

    // Monitor: pops the scoreboard whenever a data_ok is presented.
    always @(negedge clk) begin
        exp_t e;
        if (inst_data_ok) begin
            tests++;
            if (iq.size() == 0) begin
                fails++;
                $display("FAIL inst_resp_unexpected: got data_ok=1 want 0 (cyc %0d)", cyc);
            end else begin
                e = iq.pop_front();
                if (cyc != e.cyc + 1 || (e.chk && inst_rdata !== e.val)) begin
                    fails++;
                    $display("FAIL inst_resp: got %h at cyc %0d want %h at cyc %0d",
                             inst_rdata, cyc, e.val, e.cyc + 1);
                end
            end
        end
        if (data_data_ok) begin
            tests++;
            if (dq.size() == 0) begin
                fails++;
                $display("FAIL data_resp_unexpected: got data_ok=1 want 0 (cyc %0d)", cyc);
            end else begin
                e = dq.pop_front();
                if (cyc != e.cyc + 1 || (e.chk && data_rdata !== e.val)) begin
                    fails++;
                    $display("FAIL data_resp: got %h at cyc %0d want %h at cyc %0d",
                             data_rdata, cyc, e.val, e.cyc + 1);
                end
            end
        end
        tests++;
        if ((!inst_data_ok && inst_rdata !== 32'h0) || (!data_data_ok && data_rdata !== 32'h0)) begin
            fails++;
            $display("FAIL idle_rdata: got inst %h data %h want 0 0", inst_rdata, data_rdata);
        end
        tests++;
        if (inst_addr_ok && data_addr_ok) begin
            fails++;
            $display("FAIL both_addr_ok: got 11 want at most one (cyc %0d)", cyc);
        end
    end

    task automatic drive(input string name,
                         input logic ireq, input logic [31:0] iaddr,
                         input logic dreq, input logic dwr, input logic [3:0] strb,
                         input logic [31:0] daddr, input logic [31:0] wdata,
                         input logic exp_i, input logic exp_d, input logic [3:0] exp_we,
                         input logic [31:0] exp_val, input logic chk, input bit push);
        exp_t e;
        inst_req = ireq; inst_addr = iaddr;
        data_req = dreq; data_wr = dwr; data_wstrb = strb;
        data_addr = daddr; data_wdata = wdata;
        @(negedge clk);
        tests++;
        if ({inst_addr_ok, data_addr_ok} !== {exp_i, exp_d}) begin
            fails++;
            $display("FAIL %s addr_ok: got i%b d%b want i%b d%b", name,
                     inst_addr_ok, data_addr_ok, exp_i, exp_d);
        end
        tests++;
        if ({sram_en, sram_we} !== {exp_i | exp_d, exp_we} ||
            (exp_d && sram_addr !== daddr) || (exp_i && sram_addr !== iaddr) ||
            (exp_i && sram_wdata !== 32'h0) || (exp_d && dwr && sram_wdata !== wdata)) begin
            fails++;
            $display("FAIL %s sram_drive: got en%b we%h a%h wd%h want en%b we%h", name,
                     sram_en, sram_we, sram_addr, sram_wdata, exp_i | exp_d, exp_we);
        end
        e.cyc = cyc; e.chk = chk; e.val = exp_val;
        if (push && exp_i) iq.push_back(e);
        if (push && exp_d) dq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input string name);
        drive(name, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 0, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        tests++;
        if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en, sram_we,
             inst_rdata, data_rdata} !== '0) begin
            fails++;
            $display("FAIL %s: got iok%b idok%b dok%b ddok%b en%b we%h ir%h dr%h want all 0",
                     name, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                     sram_en, sram_we, inst_rdata, data_rdata);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        mem[32'h1c000000] = 32'h02800000;
        mem[32'h00000000] = 32'h11111111;
        mem[32'h00000004] = 32'h22222222;
        mem[32'h00000008] = 32'h33333333;
        reset = 1'b1;
        inst_req = 1'b1; inst_addr = 32'h0;
        data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
        data_addr = 32'h100; data_wdata = 32'h0;
        @(posedge clk); #1;

        // Requests held high during reset must not be granted.
        check_reset_outputs("reset_hold0");
        check_reset_outputs("reset_hold1");
        reset = 1'b0;
        idle("post_reset_idle");

        // Lone fetch.
        drive("fetch_lone", 1, 32'h1c000000, 0, 0, 4'h0, 32'h0, 32'h0,
              1, 0, 4'h0, 32'h02800000, 1, 1);
        idle("idle1");

        // Write then read back the same word.
        drive("data_write", 0, 32'h0, 1, 1, 4'hF, 32'h100, 32'hdeadbeef,
              0, 1, 4'hF, 32'h0, 0, 1);
        drive("data_read", 0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0,
              0, 1, 4'h0, 32'hdeadbeef, 1, 1);
        idle("idle2");

        // Back-to-back fetches.
        drive("fetch_b2b0", 1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h11111111, 1, 1);
        drive("fetch_b2b1", 1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h22222222, 1, 1);
        drive("fetch_b2b2", 1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'h0, 32'h33333333, 1, 1);
        idle("idle3");

        // Contention: four data grants then one fetch, repeating.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4)
                drive("contend_inst", 1, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0,
                      1, 0, 4'h0, 32'h11111111, 1, 1);
            else
                drive("contend_data", 1, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0,
                      0, 1, 4'h0, 32'hdeadbeef, 1, 1);
        end
        idle("idle4");

        // Reset right after a read grant: its response must vanish.
        drive("read_before_reset", 0, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0,
              0, 1, 4'h0, 32'h0, 0, 0);
        reset = 1'b1;
        check_reset_outputs("reset_drops_resp");
        reset = 1'b0;
        idle("after_reset_idle");

`ifdef ARB_STATS_EN
        @(negedge clk);
        tests++;
        if (stat_inst_grants !== 32'd0 || stat_data_grants !== 32'd0) begin
            fails++;
            $display("FAIL stats_reset: got i%0d d%0d want 0 0", stat_inst_grants, stat_data_grants);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            drive("stat_data", 0, 32'h0, 1, 0, 4'h0, 32'h100, 32'h0,
                  0, 1, 4'h0, 32'hdeadbeef, 1, 1);
        for (int i = 0; i < 2; i++)
            drive("stat_inst", 1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0,
                  1, 0, 4'h0, 32'h22222222, 1, 1);
        idle("stat_idle");
        @(negedge clk);
        tests++;
        if (stat_inst_grants !== 32'd2 || stat_data_grants !== 32'd3) begin
            fails++;
            $display("FAIL stats_count: got i%0d d%0d want 2 3", stat_inst_grants, stat_data_grants);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (stat_inst_grants !== 32'd0 || stat_data_grants !== 32'd0) begin
            fails++;
            $display("FAIL stats_clear: got i%0d d%0d want 0 0", stat_inst_grants, stat_data_grants);
        end
        @(posedge clk); #1;
`endif

        idle("drain0");
        idle("drain1");
        tests++;
        if (iq.size() != 0 || dq.size() != 0) begin
            fails++;
            $display("FAIL missing_resp: got %0d inst %0d data outstanding want 0 0",
                     iq.size(), dq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
